// File: rtl/mem_pkg.sv
// Shared encodings and default geometry for the MEM-stage load/store unit.
package mem_pkg;

    localparam int unsigned DEF_MEM_WORDS = 1024;
    localparam int unsigned DEF_IDX_W     = 10;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_RMW_WRITE
    } lsu_state_e;

    // Size 3 is reported here as well, so the caller only adds the range check.
    function automatic logic size_fault(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/response and data-memory bus of the MEM-stage LSU.
// master: the pipeline plus memory environment; slave: the LSU itself.
interface mem_stage_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        stall;

    logic [31:0] mem_address;
    logic        mem_readEn;
    logic        mem_writeEn;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, stall,
        input  mem_address, mem_readEn, mem_writeEn, mem_writeData
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
        output req_ready, rsp_valid, rsp_data, rsp_fault, stall,
        output mem_address, mem_readEn, mem_writeEn, mem_writeData
    );

endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte/half lane handling: load extraction with sign/zero extension and
// store merge of new data into the old memory word.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = old_word[7:0];
        case (addr_lo)
            2'd0: byte_lane = old_word[7:0];
            2'd1: byte_lane = old_word[15:8];
            2'd2: byte_lane = old_word[23:16];
            2'd3: byte_lane = old_word[31:24];
        endcase
        half_lane = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        load_data = old_word;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: load_data = old_word;
        endcase
    end

    always_comb begin
        merged_word = old_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0: merged_word[7:0]   = store_data[7:0];
                    2'd1: merged_word[15:8]  = store_data[7:0];
                    2'd2: merged_word[23:16] = store_data[7:0];
                    2'd3: merged_word[31:24] = store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) merged_word[31:16] = store_data[15:0];
                else            merged_word[15:0]  = store_data[15:0];
            end
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: fault checks, 1-cycle loads and word stores,
// two-cycle read-modify-write for sub-word stores.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
    parameter int unsigned IDX_W     = DEF_IDX_W
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_lsu_if.slave bus
);

    lsu_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      merge_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_fault_q;

    logic [IDX_W-1:0] req_idx;
    logic             in_idle;
    logic             in_rmw;
    logic             fault;
    logic             accept;
    logic             go;
    logic             word_store;
    logic [31:0]      load_data;
    logic [31:0]      merged_word;

    assign req_idx    = bus.req_addr[IDX_W+1:2];
    assign in_idle    = (state_q == ST_IDLE);
    assign in_rmw     = (state_q == ST_RMW_WRITE);
    // Word index beyond the memory covers every nonzero bit above addr[IDX_W+1].
    assign fault      = size_fault(bus.req_size, bus.req_addr[1:0]) ||
                        ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS);
    // Gated by rst so no enable can leak out while reset is held.
    assign accept     = bus.req_valid && in_idle && rst;
    assign go         = accept && !fault;
    assign word_store = bus.req_we && (bus.req_size == SZ_WORD);

    lsu_lane_align u_lane_align (
        .addr_lo     (bus.req_addr[1:0]),
        .size        (bus.req_size),
        .is_unsigned (bus.req_unsigned),
        .old_word    (bus.mem_readData),
        .store_data  (bus.req_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign bus.req_ready = in_idle;
    assign bus.stall     = bus.req_valid && !in_idle;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fault = rsp_fault_q;

    // Loads and the read half of an RMW share the read port; only one enable per cycle.
    assign bus.mem_readEn    = go && !word_store;
    assign bus.mem_writeEn   = (go && word_store) || in_rmw;
    assign bus.mem_address   = in_rmw ? {{(32-IDX_W){1'b0}}, idx_q}   :
                               go     ? {{(32-IDX_W){1'b0}}, req_idx} : 32'd0;
    assign bus.mem_writeData = in_rmw                ? merge_q       :
                               (go && word_store)    ? bus.req_wdata : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            merge_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (fault) begin
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                        end else if (!bus.req_we) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= load_data;
                        end else if (word_store) begin
                            rsp_valid_q <= 1'b1;
                        end else begin
                            merge_q <= merged_word;
                            idx_q   <= req_idx;
                            state_q <= ST_RMW_WRITE;
                        end
                    end
                end
                ST_RMW_WRITE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a falling-edge-write word memory model.
module tb_mem_stage_lsu;
    import mem_pkg::*;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          lat;
        int          nw;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_writes = 0;
    int   n_excl = 0;

    logic [31:0] mem [0:1023];

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(
        .MEM_WORDS (1024),
        .IDX_W     (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_readData = mem[bus.mem_address[9:0]];

    always @(negedge clk) begin
        if (bus.mem_writeEn === 1'b1) begin
            mem[bus.mem_address[9:0]] <= bus.mem_writeData;
            n_writes <= n_writes + 1;
        end
        if (bus.mem_readEn === 1'b1 && bus.mem_writeEn === 1'b1) n_excl <= n_excl + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_valid    = 1'b1;
    endtask

    // Issue one request from IDLE; returns cycles from acceptance to rsp_valid.
    task automatic do_req(input vec_t v, output int lat, output logic [31:0] data,
                          output logic flt);
        drive(v);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 4) begin
            @(posedge clk); #1;
            lat++;
        end
        data = bus.rsp_data;
        flt  = bus.rsp_fault;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[26];
        vec_t        bb[9];
        logic [31:0] bb_exp[9];
        int          bb_cyc[9] = '{0, 1, 2, 3, 5, 6, 7, 8, 9};
        logic [31:0] got_d[$];
        int          got_c[$];
        int          lat;
        logic [31:0] data;
        logic        flt;
        int          w0;
        int          idx;
        int          n_stall;
        logic        acc;

        //           we    size     uns   addr          wdata         exp           flt  lat nw
        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 1, 1};
        vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 1, 0};
        vecs[2]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,       32'h80FF7F01, 32'h0,        1'b0, 1, 1};
        vecs[3]  = '{1'b0, SZ_BYTE, 1'b0, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0, 1, 0};
        vecs[4]  = '{1'b0, SZ_BYTE, 1'b1, 32'h13,       32'h0,        32'h00000080, 1'b0, 1, 0};
        vecs[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h10,       32'h0,        32'h00007F01, 1'b0, 1, 0};
        vecs[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h12,       32'h0,        32'h000080FF, 1'b0, 1, 0};
        vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 32'h12,       32'h0,        32'hFFFF80FF, 1'b0, 1, 0};
        vecs[8]  = '{1'b0, SZ_BYTE, 1'b0, 32'h11,       32'h0,        32'h0000007F, 1'b0, 1, 0};
        vecs[9]  = '{1'b0, SZ_BYTE, 1'b0, 32'h12,       32'h0,        32'hFFFFFFFF, 1'b0, 1, 0};
        vecs[10] = '{1'b1, SZ_WORD, 1'b0, 32'h10,       32'h11223344, 32'h0,        1'b0, 1, 1};
        vecs[11] = '{1'b1, SZ_BYTE, 1'b0, 32'h11,       32'h000000AA, 32'h0,        1'b0, 2, 1};
        vecs[12] = '{1'b0, SZ_WORD, 1'b0, 32'h10,       32'h0,        32'h1122AA44, 1'b0, 1, 0};
        vecs[13] = '{1'b1, SZ_HALF, 1'b0, 32'h12,       32'hFFFFBEEF, 32'h0,        1'b0, 2, 1};
        vecs[14] = '{1'b0, SZ_WORD, 1'b0, 32'h10,       32'h0,        32'hBEEFAA44, 1'b0, 1, 0};
        vecs[15] = '{1'b0, SZ_HALF, 1'b0, 32'h13,       32'h0,        32'h0,        1'b1, 1, 0};
        vecs[16] = '{1'b0, SZ_WORD, 1'b0, 32'h12,       32'h0,        32'h0,        1'b1, 1, 0};
        vecs[17] = '{1'b0, SZ_BYTE, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1, 1, 0};
        vecs[18] = '{1'b0, 2'd3,    1'b0, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0};
        vecs[19] = '{1'b1, SZ_WORD, 1'b0, 32'h1000,     32'hCAFEF00D, 32'h0,        1'b1, 1, 0};
        vecs[20] = '{1'b1, SZ_HALF, 1'b0, 32'h11,       32'h00001234, 32'h0,        1'b1, 1, 0};
        vecs[21] = '{1'b1, 2'd3,    1'b0, 32'h10,       32'h00005555, 32'h0,        1'b1, 1, 0};
        vecs[22] = '{1'b0, SZ_WORD, 1'b1, 32'h10,       32'h0,        32'hBEEFAA44, 1'b0, 1, 0};
        vecs[23] = '{1'b1, SZ_BYTE, 1'b0, 32'h13,       32'h5A5A5A77, 32'h0,        1'b0, 2, 1};
        vecs[24] = '{1'b0, SZ_WORD, 1'b0, 32'h10,       32'h0,        32'h77EFAA44, 1'b0, 1, 0};
        vecs[25] = '{1'b0, SZ_BYTE, 1'b0, 32'h40000010, 32'h0,        32'h0,        1'b1, 1, 0};

        // Back-to-back stream, run after word 4 = 0x77EFAA55 and word 8 = 0x12345678.
        bb[0] = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,  32'h0, 1'b0, 1, 0};
        bb[1] = '{1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0,  32'h0, 1'b0, 1, 0};
        bb[2] = '{1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0,  32'h0, 1'b0, 1, 0};
        bb[3] = '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,  32'h0, 1'b0, 1, 0};
        bb[4] = '{1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h99, 32'h0, 1'b0, 2, 1};
        bb[5] = '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,  32'h0, 1'b0, 1, 0};
        bb[6] = '{1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0,  32'h0, 1'b0, 1, 0};
        bb[7] = '{1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,  32'h0, 1'b0, 1, 0};
        bb[8] = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,  32'h0, 1'b0, 1, 0};
        bb_exp = '{32'h77EFAA55, 32'h00000078, 32'h00001234, 32'h12345678, 32'h0,
                   32'h12349978, 32'h000000AA, 32'h000077EF, 32'h77EFAA55};

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_data", bus.rsp_data, 32'h0);
        chk("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);
        chk("reset enables", {30'd0, bus.mem_readEn, bus.mem_writeEn}, 32'd0);
        chk("reset mem_address", bus.mem_address, 32'h0);
        chk("reset mem_writeData", bus.mem_writeData, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle no enables", {30'd0, bus.mem_readEn, bus.mem_writeEn}, 32'd0);

        for (int i = 0; i < 26; i++) begin
            w0 = n_writes;
            do_req(vecs[i], lat, data, flt);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d rsp_data", i), data, vecs[i].exp_data);
            chk($sformatf("vec%0d rsp_fault", i), 32'(flt), 32'(vecs[i].exp_fault));
            @(posedge clk); #1;
            chk($sformatf("vec%0d rsp pulse", i), 32'(bus.rsp_valid), 32'd0);
            chk($sformatf("vec%0d writes", i), 32'(n_writes - w0), 32'(vecs[i].nw));
        end

        // Sub-word store with a load held behind it: stall, write phase, merged readback.
        drive('{1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h55, 32'h0, 1'b0, 2, 1});
        @(posedge clk); #1;
        drive('{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1, 0});
        #1;
        chk("rmw stall", 32'(bus.stall), 32'd1);
        chk("rmw req_ready", 32'(bus.req_ready), 32'd0);
        chk("rmw enables", {30'd0, bus.mem_readEn, bus.mem_writeEn}, 32'd1);
        chk("rmw writeData", bus.mem_writeData, 32'h77EFAA55);
        chk("rmw address", bus.mem_address, 32'd4);
        chk("rmw no early rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rmw rsp_valid T+2", 32'(bus.rsp_valid), 32'd1);
        chk("rmw rsp_data", bus.rsp_data, 32'h0);
        chk("rmw stall released", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("held load rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("held load data", bus.rsp_data, 32'h77EFAA55);
        @(posedge clk); #1;

        // Reset during the write phase of a half store.
        do_req('{1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, 1, 1}, lat, data, flt);
        chk("preload word8 latency", 32'(lat), 32'd1);
        @(posedge clk); #1;
        w0 = n_writes;
        drive('{1'b1, SZ_HALF, 1'b0, 32'h20, 32'hBEEF, 32'h0, 1'b0, 2, 1});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("pre-reset writeEn", 32'(bus.mem_writeEn), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid-rmw reset writeEn", 32'(bus.mem_writeEn), 32'd0);
        chk("mid-rmw reset readEn", 32'(bus.mem_readEn), 32'd0);
        chk("mid-rmw reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid-rmw reset rsp", {bus.rsp_valid, bus.rsp_fault, 30'd0} | bus.rsp_data, 32'h0);
        chk("mid-rmw reset address", bus.mem_address, 32'h0);
        chk("mid-rmw reset writeData", bus.mem_writeData, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post-reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("post-reset no rsp", 32'(bus.rsp_valid), 32'd0);
        chk("post-reset word8", mem[8], 32'h12345678);
        chk("post-reset no write", 32'(n_writes - w0), 32'd0);

        // Back-to-back loads with one sub-word store in the middle.
        idx = 0;
        n_stall = 0;
        for (int c = 0; c < 14; c++) begin
            if (idx < 9) drive(bb[idx]);
            else bus.req_valid = 1'b0;
            #1;
            if (bus.stall === 1'b1) n_stall++;
            acc = (idx < 9) && (bus.req_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) idx++;
            if (bus.rsp_valid === 1'b1) begin
                got_d.push_back(bus.rsp_data);
                got_c.push_back(c);
            end
        end
        chk("stream accepted", 32'(idx), 32'd9);
        chk("stream responses", 32'(got_d.size()), 32'd9);
        chk("stream stall cycles", 32'(n_stall), 32'd1);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("stream rsp%0d data", k),
                (k < got_d.size()) ? got_d[k] : 32'hXXXXXXXX, bb_exp[k]);
            chk($sformatf("stream rsp%0d cycle", k),
                (k < got_c.size()) ? 32'(got_c[k]) : 32'hFFFFFFFF, 32'(bb_cyc[k]));
        end

        chk("enable exclusivity", 32'(n_excl), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit in the MEM stage, directly upstream of the data memory. It takes EX/MEM memory requests (byte, halfword or word) and does alignment and range checks. It drives the memory's word-indexed read/write port and returns sign- or zero-extended load data to the MEM/WB register. Sub-word stores use a two-cycle read-modify-write, because the memory only writes full words; the pipeline stalls during it.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the data memory.
IDX_W, 10, word-index width (log2 of MEM_WORDS).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  memory request present from EX/MEM.
req_ready  out  1  unit can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
req_unsigned  in  1  zero-extend a load when 1, sign-extend when 0.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
rsp_valid  out  1  one-cycle pulse marking completion of an accepted request.
rsp_data  out  32  extended load data; 0 for stores and faults.
rsp_fault  out  1  misaligned, out-of-range or illegal-size request.
stall  out  1  req_valid && !req_ready, sent to the hazard unit.
mem_address  out  32  word index {zeros, addr[IDX_W+1:2]}.
mem_readEn  out  1  memory read enable.
mem_writeEn  out  1  memory write enable; the memory samples it on the falling clk edge.
mem_writeData  out  32  full word to write.
mem_readData  in  32  memory read data, combinational from address.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_fault=0.
  - The merge register clears.
  - mem_readEn, mem_writeEn, mem_address and mem_writeData are all 0.
- Acceptance: a request is accepted at a rising edge where req_valid && req_ready. req_ready=1 only in IDLE.
- Fault check, combinational on the request:
  - size 3 is illegal.
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - addr[31:IDX_W+2]!=0 is out of range.
  - A faulting request drives no memory enables. rsp_valid=1, rsp_fault=1 and rsp_data=0 in the next cycle. State stays IDLE.
- States: IDLE, RMW_WRITE.
- Load in IDLE:
  - mem_readEn=1 and mem_address are driven combinationally during the accept cycle.
  - The selected lane (byte addr[1:0], half addr[1]) is extended and registered.
  - Latency 1: rsp_valid and rsp_data appear in cycle T+1. Back-to-back loads complete every cycle.
- Word store in IDLE:
  - mem_writeEn=1 and mem_writeData=req_wdata in the accept cycle T, so the memory writes at the falling edge of T.
  - rsp_valid in T+1.
- Sub-word store, accepted at T:
  - In T: mem_readEn=1. Old word = mem_readData. The merged word (new byte/half inserted at its lane, other lanes kept) is captured into the merge register.
  - Transition to RMW_WRITE.
  - In T+1: req_ready=0, mem_writeEn=1, mem_writeData = merge register, mem_address held from T.
  - Return to IDLE. rsp_valid in T+2.
- Enable exclusivity: mem_readEn and mem_writeEn are never both 1 in the same cycle.
- Unaccepted cycles: memory enables are 0 in all cycles without an accepted request, including while req_valid=0.
- Store response data: rsp_data=0 for stores.
- rsp_valid pulse: high exactly one cycle per accepted request.
- Reset mid-RMW: asserting rst during RMW_WRITE drops mem_writeEn immediately (asynchronous). No write is issued, no response is given, and the state returns to IDLE.
- Requests held during RMW_WRITE: req_valid held high during RMW_WRITE is accepted on the cycle state returns to IDLE, with no loss or duplication.
- Store-then-load to the same word: a load accepted at T+2 after a sub-word store at T returns the merged value, because the write landed at the falling edge of T+1.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - state encodings ST_IDLE, ST_RMW_WRITE;
  - MEM_WORDS and IDX_W defaults.
- One combinational sub-module, lsu_lane_align, performs:
  - load lane select plus sign/zero extension;
  - store lane merge into the old word.
  It is reused for both paths. The top level holds the FSM, fault check and registers.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x10 (index 4), then load word at 0x10 → rsp_data=0xDEADBEEF, rsp_fault=0, response one cycle after the load is accepted.
- Byte loads: memory[4]=0x80FF7F01; load byte at 0x13 signed → 0xFFFFFF80; unsigned → 0x00000080; half at 0x10 signed → 0x00007F01.
- Sub-word store RMW: memory[4]=0x11223344; store byte 0xAA at 0x11 → stall high for 1 cycle, memory[4]=0x1122AA44, rsp_valid at T+2; immediate load word at 0x10 → 0x1122AA44.
- Faults: half at 0x13, word at 0x12, byte at 0x00001000, size 3 → each gives rsp_fault=1 and rsp_data=0, mem_writeEn never asserted, memory unchanged.
- Reset mid-RMW: start a half store 0xBEEF at 0x20; pull rst low during RMW_WRITE → mem_writeEn=0, memory[8] unchanged, all outputs at reset values, req_ready=1 after release.
- Back-to-back: 8 consecutive loads with req_valid held high → 8 rsp_valid pulses on consecutive cycles; a sub-word store inserted mid-stream → exactly one bubble, ordering preserved.
